// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue stage.
// Optional feature macro: ALU_ISSUE_TRAP_EN (adds the HALT state on illegal opcodes).
package alu_issue_pkg;

   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned OP_W     = 4;
   localparam int unsigned REG_AW   = 3;
   localparam int unsigned PSW_W    = 3;
   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned IMM_W    = 9;

   // Opcode values
   localparam logic [OP_W-1:0] OP_AND = 4'd0;
   localparam logic [OP_W-1:0] OP_OR  = 4'd1;
   localparam logic [OP_W-1:0] OP_XOR = 4'd2;
   localparam logic [OP_W-1:0] OP_NOT = 4'd3;
   localparam logic [OP_W-1:0] OP_ADD = 4'd4;
   localparam logic [OP_W-1:0] OP_SUB = 4'd5;
   localparam logic [OP_W-1:0] OP_SHR = 4'd6;
   localparam logic [OP_W-1:0] OP_SHL = 4'd7;
   localparam logic [OP_W-1:0] OP_LDI = 4'd8;

   // Instruction field bit positions
   localparam int unsigned OP_HI  = 15;
   localparam int unsigned OP_LO  = 12;
   localparam int unsigned RD_HI  = 11;
   localparam int unsigned RD_LO  = 9;
   localparam int unsigned RS1_HI = 8;
   localparam int unsigned RS1_LO = 6;
   localparam int unsigned RS2_HI = 5;
   localparam int unsigned RS2_LO = 3;
   localparam int unsigned IMM_HI = 8;
   localparam int unsigned IMM_LO = 0;

`ifdef ALU_ISSUE_TRAP_EN
   typedef enum logic [1:0] {StIdle, StIssue, StWb, StHalt} state_t;
`else
   typedef enum logic [1:0] {StIdle, StIssue, StWb} state_t;
`endif

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two combinational operand reads, one debug read,
// one synchronous write port, asynchronous clear, r0 reads as zero.
module alu_regfile
   import alu_issue_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [REG_AW-1:0] i_raddr1,
   output logic [DATA_W-1:0] o_rdata1,
   input  logic [REG_AW-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata2,
   input  logic [REG_AW-1:0] i_dbg_addr,
   output logic [DATA_W-1:0] o_dbg_data
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   // Storage: cleared on reset; writes to r0 are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Read ports with r0 forced to zero
   always_comb begin
      o_rdata1   = (i_raddr1   == '0) ? '0 : r_regs[i_raddr1];
      o_rdata2   = (i_raddr2   == '0) ? '0 : r_regs[i_raddr2];
      o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for the 16-bit ALU: handshake in, decode, register-file read,
// registered ALU operands, write-back of result and PSW capture.
// One instruction in flight; IDLE -> ISSUE -> WB -> IDLE.
// Optional feature macro: ALU_ISSUE_TRAP_EN (illegal opcode parks the FSM in HALT).
module alu_issue_stage
   import alu_issue_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic [OP_W-1:0]    alu_opcode,
   output logic [DATA_W-1:0]  alu_src1,
   output logic [DATA_W-1:0]  alu_src2,
   input  logic [DATA_W-1:0]  alu_td,
   input  logic [PSW_W-1:0]   alu_psw,
   output logic               wb_valid,
   output logic [REG_AW-1:0]  wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   output logic [PSW_W-1:0]   psw,
   output logic               illegal,
   input  logic [REG_AW-1:0]  dbg_addr,
   output logic [DATA_W-1:0]  dbg_data
);

   state_t               r_state;
   state_t               w_state_d;
   logic [INSTR_W-1:0]   r_instr;
   logic [OP_W-1:0]      r_alu_opcode;
   logic [DATA_W-1:0]    r_alu_src1;
   logic [DATA_W-1:0]    r_alu_src2;
   logic [PSW_W-1:0]     r_psw;

   logic [OP_W-1:0]      w_op;
   logic [REG_AW-1:0]    w_rd;
   logic [REG_AW-1:0]    w_rs1;
   logic [REG_AW-1:0]    w_rs2;
   logic [IMM_W-1:0]     w_imm9;
   logic                 w_is_alu;
   logic                 w_is_ldi;
   logic                 w_is_ill;
   logic                 w_in_wb;
   logic                 w_we;
   logic [DATA_W-1:0]    w_wdata;
   logic [DATA_W-1:0]    w_rs1_data;
   logic [DATA_W-1:0]    w_rs2_data;

   // Decode of the latched instruction
   always_comb begin
      w_op     = r_instr[OP_HI:OP_LO];
      w_rd     = r_instr[RD_HI:RD_LO];
      w_rs1    = r_instr[RS1_HI:RS1_LO];
      w_rs2    = r_instr[RS2_HI:RS2_LO];
      w_imm9   = r_instr[IMM_HI:IMM_LO];
      w_is_alu = ~w_op[OP_W-1];
      w_is_ldi = (w_op == OP_LDI);
      w_is_ill = w_op[OP_W-1] & ~w_is_ldi;
      w_in_wb  = (r_state == StWb);
      w_we     = w_in_wb & (w_is_alu | w_is_ldi);
      w_wdata  = w_is_ldi ? {{(DATA_W-IMM_W){1'b0}}, w_imm9} : alu_td;
   end

   alu_regfile u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (w_we),
      .i_waddr    (w_rd),
      .i_wdata    (w_wdata),
      .i_raddr1   (w_rs1),
      .o_rdata1   (w_rs1_data),
      .i_raddr2   (w_rs2),
      .o_rdata2   (w_rs2_data),
      .i_dbg_addr (dbg_addr),
      .o_dbg_data (dbg_data)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (instr_valid) w_state_d = StIssue;
         StIssue: w_state_d = StWb;
`ifdef ALU_ISSUE_TRAP_EN
         StWb:    w_state_d = w_is_ill ? StHalt : StIdle;
         StHalt:  w_state_d = StHalt;
`else
         StWb:    w_state_d = StIdle;
`endif
         default: w_state_d = StIdle;
      endcase
   end

   // Instruction latch on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= '0;
      end else if ((r_state == StIdle) && instr_valid) begin
         r_instr <= instr;
      end
   end

   // ALU operand registers, loaded in ISSUE and held until the next ISSUE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_opcode <= '0;
         r_alu_src1   <= '0;
         r_alu_src2   <= '0;
      end else if (r_state == StIssue) begin
         r_alu_opcode <= w_op;
         r_alu_src1   <= w_rs1_data;
         r_alu_src2   <= w_rs2_data;
      end
   end

   // PSW capture, only for real ALU operations
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_psw <= '0;
      end else if (w_in_wb && w_is_alu) begin
         r_psw <= alu_psw;
      end
   end

   // Outputs; write-back fields read zero outside the write pulse
   always_comb begin
      instr_ready = (r_state == StIdle);
      alu_opcode  = r_alu_opcode;
      alu_src1    = r_alu_src1;
      alu_src2    = r_alu_src2;
      psw         = r_psw;
      wb_valid    = w_we;
      wb_addr     = w_we ? w_rd : '0;
      wb_data     = w_we ? w_wdata : '0;
      illegal     = w_in_wb & w_is_ill;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Upstream issue stage for the 16-bit ALU: accepts 16-bit instruction words over a valid/ready handshake, decodes them, reads an 8×16 register file and drives registered opcode and operands to the combinational ALU. It then captures the ALU result (td) and flags (PSW), writes the result back to the register file and holds the PSW in a status register. One instruction is in flight at a time.

## Interface
- `NUM_REGS`, 8: register-file depth; fixed at 8 because the instruction has 3-bit register fields.
- `DATA_W`, 16: datapath width; must equal the ALU width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `instr_valid` input 1: the instruction word is valid.
- `instr` input 16: instruction word.
- `instr_ready` output 1: the stage accepts `instr` this cycle.
- `alu_opcode` output 4: registered ALU opcode.
- `alu_src1` output 16: registered ALU operand 1.
- `alu_src2` output 16: registered ALU operand 2.
- `alu_td` input 16: ALU result, combinational from the `alu_*` outputs.
- `alu_psw` input 3: ALU flags.
- `wb_valid` output 1: one-cycle pulse when a register write occurs.
- `wb_addr` output 3: register written.
- `wb_data` output 16: value written.
- `psw` output 3: last captured ALU flags.
- `illegal` output 1: one-cycle pulse when an illegal opcode is consumed.
- `dbg_addr` input 3: debug read address.
- `dbg_data` output 16: combinational register read; r0 always reads 0.

## Operation
Instruction fields:
- [15:12] op
- [11:9] rd
- [8:6] rs1
- [5:3] rs2
- [8:0] imm9 (LDI only)

Opcode classes:
- op 0–7: ALU op. Operands are r[rs1] and r[rs2]. Result is written to rd, and `psw` is updated from `alu_psw`.
- op 8 (LDI): rd ← {7'b0, imm9}. The ALU is not used and `psw` holds.
- op 9–15: illegal. No register write, `psw` holds, `illegal` pulses.

Register file rules:
- r0 is hard-wired to zero; writes to it are discarded.
- `wb_valid` still pulses with `wb_addr`=0 and `wb_data` equal to the discarded value.

FSM states: IDLE, ISSUE, WB.
- IDLE: `instr_ready`=1. When `instr_valid`=1, latch `instr` and go to ISSUE.
- ISSUE: register `alu_opcode`/`alu_src1`/`alu_src2` from the latched instruction. Go to WB.
  - For LDI and illegal ops, operands are still driven; the values are don't-care.
- WB: sample `alu_td`/`alu_psw` (ALU ops), or form the immediate (LDI). Perform the register write, the `wb_*` pulse and the `psw` update, then go to IDLE.
  - For illegal ops, pulse `illegal` instead.

Reset values:
- All outputs are 0, with one exception: `instr_ready` is 1 in IDLE after reset.
- All registers in the register file are 0.

Asynchronous reset mid-operation: return to IDLE immediately. The in-flight instruction is discarded with no write, no `wb_valid` and no `illegal`.

## Timing
- Cycle 0: handshake (`instr_valid` & `instr_ready`).
- Cycle 1: ISSUE; `alu_*` outputs are valid from the following edge onward.
- Cycle 2: WB; `wb_valid`/`illegal` are asserted during this cycle. The write and the `psw` update take effect at the end of cycle 2.
- Cycle 3: IDLE; `instr_ready`=1 again.
- Throughput: one instruction per 3 cycles.
- `instr_ready` is 0 in ISSUE and WB. Valid held high is accepted only in IDLE.
- `alu_*` outputs hold their values until the next ISSUE.
- `dbg_data` reflects a write starting the cycle after WB.
- A read-after-write in the next instruction sees the new value, because the write completes before the next ISSUE.

## Configuration
- `ALU_ISSUE_TRAP_EN` defined: an illegal opcode sets a sticky trap in WB and pulses `illegal`.
  - The FSM then parks in a fourth state, HALT, with `instr_ready`=0.
  - HALT is left only by `rst_n`.
- `ALU_ISSUE_TRAP_EN` undefined: an illegal opcode behaves as a NOP with the `illegal` pulse. There is no HALT state.

## Structure
- Package `alu_issue_pkg` contains:
  - the opcode constants (AND=0, OR=1, XOR=2, NOT=3, ADD=4, SUB=5, SHR=6, SHL=7, LDI=8);
  - the state enum;
  - the field bit positions;
  - `NUM_REGS`/`DATA_W`.
- One sub-module, `alu_regfile`:
  - two combinational read ports for rs1/rs2, plus the debug read port;
  - one synchronous write port;
  - asynchronous clear;
  - r0 forced to zero.

## Test plan
In every scenario the bench models the ALU, driving `alu_td`/`alu_psw` combinationally from `alu_*`.
- Reset: assert `rst_n`=0 → all outputs 0 and all `dbg_data` reads 0. Release → `instr_ready`=1.
- LDI r1,0x1FF (`instr`=0x83FF) → cycle 2: `wb_valid`=1, `wb_addr`=1, `wb_data`=0x01FF, `psw` stays 000. `dbg_data`(r1)=0x01FF.
- r1=5, r2=3, ADD r3 (`instr`=0x4650):
  - ISSUE → `alu_opcode`=4, `alu_src1`=5, `alu_src2`=3.
  - Model returns td=8, PSW=000 → r3=0x0008.
  - Repeat with a model PSW=101 → `psw`=101.
- Write to r0 (LDI r0,0x055) → `wb_valid` pulses with `wb_addr`=0, and `dbg_data`(r0) stays 0.
- Illegal op 0xA000:
  - Macro off → `illegal` pulses, no `wb_valid`, `instr_ready`=1 at cycle 3.
  - Macro on → `instr_ready` stays 0 until reset.
- `instr_valid` held high with 3 instructions queued → accepted at cycles 0, 3 and 6. Then assert `rst_n` low during the ISSUE of a fourth instruction (LDI r4,0x001) → no write, r4=0, FSM in IDLE.
